// File: rtl/id_ex_stage.sv
// ID/EX operand-capture stage: a 2-entry skid buffer with a valid/ready handshake and writeback patching of stale operands.
// Build option: define ID_EX_BYPASS_EN to enable the capture bypass and hold patching.
module id_ex_stage #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 6,
  parameter int OPW   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_opcode,
  input  logic [AW-1:0]  in_rd,
  input  logic [AW-1:0]  in_rs,
  input  logic [AW-1:0]  in_rt,
  input  logic [DW-1:0]  in_a,
  input  logic [DW-1:0]  in_b,
  input  logic           wb_regWrite,
  input  logic [AW-1:0]  wb_writeReg,
  input  logic [DW-1:0]  wb_writeData,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_opcode,
  output logic [AW-1:0]  out_rd,
  output logic [AW-1:0]  out_rs,
  output logic [AW-1:0]  out_rt,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b
);

`ifdef ID_EX_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  if (DEPTH != 2) begin : g_depth_check
    $error("id_ex_stage supports DEPTH == 2 only");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [OPW-1:0] r_op [2];
  logic [AW-1:0]  r_rd [2];
  logic [AW-1:0]  r_rs [2];
  logic [AW-1:0]  r_rt [2];
  logic [DW-1:0]  r_a  [2];
  logic [DW-1:0]  r_b  [2];

  logic           w_push, w_pop, w_to_e0;
  logic [DW-1:0]  w_cap_a, w_cap_b, w_a0, w_b0, w_a1, w_b1;

  // The register file reads before it writes on the same edge, so any
  // operand whose source matches the writeback target is replaced here.
  function automatic logic [DW-1:0] patch(input logic [DW-1:0] val,
                                          input logic [AW-1:0] src,
                                          input logic          we,
                                          input logic [AW-1:0] wa,
                                          input logic [DW-1:0] wd);
    if (BYPASS && we && (src == wa)) return wd;
    return val;
  endfunction

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_to_e0   = w_push && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_pop));

  assign w_cap_a = patch(in_a,   in_rs,    wb_regWrite, wb_writeReg, wb_writeData);
  assign w_cap_b = patch(in_b,   in_rt,    wb_regWrite, wb_writeReg, wb_writeData);
  assign w_a0    = patch(r_a[0], r_rs[0],  wb_regWrite, wb_writeReg, wb_writeData);
  assign w_b0    = patch(r_b[0], r_rt[0],  wb_regWrite, wb_writeReg, wb_writeData);
  assign w_a1    = patch(r_a[1], r_rs[1],  wb_regWrite, wb_writeReg, wb_writeData);
  assign w_b1    = patch(r_b[1], r_rt[1],  wb_regWrite, wb_writeReg, wb_writeData);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_FULL;
          else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Flush freezes storage; the count going to EMPTY is what discards entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_op[i] <= '0;
        r_rd[i] <= '0;
        r_rs[i] <= '0;
        r_rt[i] <= '0;
        r_a[i]  <= '0;
        r_b[i]  <= '0;
      end
    end else if (!flush) begin
      if (w_to_e0) begin
        r_op[0] <= in_opcode;
        r_rd[0] <= in_rd;
        r_rs[0] <= in_rs;
        r_rt[0] <= in_rt;
        r_a[0]  <= w_cap_a;
        r_b[0]  <= w_cap_b;
      end else if (w_pop) begin
        r_op[0] <= r_op[1];
        r_rd[0] <= r_rd[1];
        r_rs[0] <= r_rs[1];
        r_rt[0] <= r_rt[1];
        r_a[0]  <= w_a1;
        r_b[0]  <= w_b1;
      end else begin
        r_a[0]  <= w_a0;
        r_b[0]  <= w_b0;
      end

      if (w_push && !w_to_e0) begin
        r_op[1] <= in_opcode;
        r_rd[1] <= in_rd;
        r_rs[1] <= in_rs;
        r_rt[1] <= in_rt;
        r_a[1]  <= w_cap_a;
        r_b[1]  <= w_cap_b;
      end else begin
        r_a[1]  <= w_a1;
        r_b[1]  <= w_b1;
      end
    end
  end

  assign out_opcode = r_op[0];
  assign out_rd     = r_rd[0];
  assign out_rs     = r_rs[0];
  assign out_rt     = r_rt[0];
  assign out_a      = r_a[0];
  assign out_b      = r_b[0];

endmodule
